// File: rtl/icache_axi_read_bridge.sv
// Icache line-refill responder: turns a one-cycle line request into a single AXI4 INCR
// read burst and packs the returned beats into one line, returned with a one-cycle valid pulse.
module icache_axi_read_bridge #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          BEAT_NUM   = 8,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cache_mem_read_en,
    input  logic [ADDR_WIDTH-1:0]          cache_mem_read_addr,
    output logic                           mem_icache_return_en,
    output logic [BEAT_NUM*DATA_WIDTH-1:0] mem_icache_return_data,
    output logic                           bridge_busy,
    output logic                           bridge_err,
    output logic [3:0]                     arid,
    output logic [ADDR_WIDTH-1:0]          araddr,
    output logic [7:0]                     arlen,
    output logic [2:0]                     arsize,
    output logic [1:0]                     arburst,
    output logic                           arvalid,
    input  logic                           arready,
    input  logic [3:0]                     rid,
    input  logic [DATA_WIDTH-1:0]          rdata,
    input  logic [1:0]                     rresp,
    input  logic                           rlast,
    input  logic                           rvalid,
    output logic                           rready
);

    localparam int OFF_BITS = $clog2(BEAT_NUM * DATA_WIDTH / 8);
    localparam int CNT_W    = $clog2(BEAT_NUM + 1);
    localparam int IDX_W    = $clog2(BEAT_NUM);
    localparam logic [CNT_W-1:0] BEATS      = CNT_W'(BEAT_NUM);
    localparam logic [CNT_W-1:0] LAST_INDEX = CNT_W'(BEAT_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t                         r_state;
    state_t                         w_next_state;
    logic [ADDR_WIDTH-1:0]          r_araddr;
    logic [BEAT_NUM*DATA_WIDTH-1:0] r_line;
    logic                           r_err;
    logic [CNT_W-1:0]               r_cnt;
    logic                           w_accept;
    logic                           w_beat;
    logic                           w_unused_bits;

    assign w_accept = (r_state == S_IDLE) && cache_mem_read_en;
    assign w_beat   = (r_state == S_DATA) && rvalid;

    // The slave ID and the in-line offset of the request address play no part in the burst.
    assign w_unused_bits = ^{rid, cache_mem_read_addr[OFF_BITS-1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (cache_mem_read_en) w_next_state = S_ADDR;
            S_ADDR: if (arready) w_next_state = S_DATA;
            S_DATA: if (rvalid && rlast) w_next_state = S_RESP;
            S_RESP: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Counter saturates at BEAT_NUM so surplus beats are dropped; any short or long burst is an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_araddr <= '0;
            r_line   <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_araddr <= {cache_mem_read_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
                r_line   <= '0;
                r_err    <= 1'b0;
                r_cnt    <= '0;
            end
            if (w_beat) begin
                if (r_cnt < BEATS) begin
                    r_line[r_cnt[IDX_W-1:0]*DATA_WIDTH +: DATA_WIDTH] <= rdata;
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
                if (rresp != 2'b00) begin
                    r_err <= 1'b1;
                end
                if (rlast && (r_cnt != LAST_INDEX)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign arid                   = AXI_ID;
    assign araddr                 = r_araddr;
    assign arlen                  = 8'(BEAT_NUM - 1);
    assign arsize                 = 3'b010;
    assign arburst                = 2'b01;
    assign arvalid                = (r_state == S_ADDR);
    assign rready                 = (r_state == S_DATA);
    assign mem_icache_return_en   = (r_state == S_RESP);
    assign mem_icache_return_data = r_line;
    assign bridge_err             = r_err;
    assign bridge_busy            = (r_state != S_IDLE);

endmodule

// File: doc/icache_axi_read_bridge.md
Name: icache_axi_read_bridge

Overview:
- Memory-side responder for the instruction cache's line-refill request.
- Accepts a one-cycle line read request (address) from the icache and issues a single AXI4 INCR read burst of BEAT_NUM 32-bit beats.
- Packs the returned beats into one BEAT_NUM*32-bit line, then returns it with a one-cycle valid pulse.
- Sits between the icache miss path and the AXI read channels of the memory interconnect.

Parameters:
ADDR_WIDTH, 32, physical address width
DATA_WIDTH, 32, AXI data width and width of one bank/beat
BEAT_NUM, 8, beats per line; returned line width = BEAT_NUM*DATA_WIDTH (256)
AXI_ID, 4'd0, constant value driven on arid

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cache_mem_read_en  in  1  icache line request strobe (one cycle)
cache_mem_read_addr  in  ADDR_WIDTH  physical address of the missing fetch
mem_icache_return_en  out  1  one-cycle pulse: line valid
mem_icache_return_data  out  BEAT_NUM*DATA_WIDTH  packed line; word i at [32i+31:32i]
bridge_busy  out  1  high in every state except IDLE
bridge_err  out  1  line completed with error; valid with return_en, held until next accepted request
arid  out  4  constant AXI_ID
araddr  out  ADDR_WIDTH  line-aligned burst address
arlen  out  8  constant BEAT_NUM-1
arsize  out  3  constant 3'b010
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  read address valid
arready  in  1  read address ready
rid  in  4  ignored
rdata  in  DATA_WIDTH  read data
rresp  in  2  read response
rlast  in  1  last beat
rvalid  in  1  read data valid
rready  out  1  read data ready

Behaviour:
- Reset values:
  - state IDLE; arvalid=0; rready=0; mem_icache_return_en=0.
  - mem_icache_return_data=0; bridge_err=0; bridge_busy=0.
  - beat counter=0; araddr=0.
  - Reset mid-burst abandons the transaction immediately. Reset is system-wide, so the AXI slave is reset too.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - When cache_mem_read_en=1, latch araddr = addr with the low log2(BEAT_NUM*4) bits (5 for the defaults) zeroed.
  - Clear the line buffer to 0, clear err and the beat counter, then go to ADDR.
- ADDR:
  - arvalid=1; araddr is stable while arvalid is high.
  - When arvalid && arready: go to DATA. arvalid drops the following cycle.
  - A combinational arready is allowed, so the handshake may occur in the first ADDR cycle.
- DATA:
  - rready=1.
  - On each rvalid && rready: if beat counter < BEAT_NUM, write rdata to word[counter]; then counter increments (saturates at BEAT_NUM).
  - Any rresp != 2'b00 sets err (sticky).
  - Beats after BEAT_NUM are discarded and set err.
  - On a beat with rlast=1, go to RESP. If the total beat count != BEAT_NUM, set err; unfilled words remain 0.
- RESP:
  - mem_icache_return_en=1 for exactly one cycle, then go to IDLE.
  - return_data and bridge_err remain stable after the pulse until the next request is accepted.
- cache_mem_read_en is ignored in every state except IDLE; no queuing.
  - A request in the RESP cycle is dropped.
  - A request in the IDLE cycle immediately after RESP is accepted.
- Minimum latency: request at cycle 0 → arvalid at cycle 1. With arready at 1 and beats at cycles 2–9 (rlast at 9), return_en is at cycle 10.
- bridge_busy is 1 in ADDR, DATA and RESP.

Test Plan:
- Basic refill:
  - Stimulus: request addr 0x1C00_0034; arready=1 immediately; 8 back-to-back beats rdata=0xA0+i with rlast on beat 7.
  - Required: araddr=0x1C00_0020, arlen=7, arsize=2, arburst=1.
  - Required: return_en at cycle 10 only; data word i = 0xA0+i; err=0.
- Backpressure and gaps:
  - Stimulus: arready low for 3 cycles; rvalid gaps between beats.
  - Required: arvalid and araddr held stable; the same packed line is returned; return_en asserted one cycle after the rlast beat.
- Error response:
  - Stimulus: beat 3 with rresp=2'b10.
  - Required: full line returned; bridge_err=1 during the pulse, held until the next request.
- Short and long bursts:
  - Stimulus: rlast on beat 5.
  - Required: words 6–7 = 0, err=1.
  - Stimulus: 9 beats with rlast on the 9th.
  - Required: 9th beat discarded, err=1.
- Request while busy:
  - Stimulus: second cache_mem_read_en during DATA, and another during RESP.
  - Required: both ignored; exactly one AR handshake.
  - Stimulus: request in the IDLE cycle after RESP.
  - Required: accepted, with arvalid on the next cycle.
- Reset mid-burst:
  - Stimulus: assert reset after beat 4.
  - Required: next cycle arvalid=0, rready=0, return_en=0, data=0, busy=0; no return pulse.
  - Required: a fresh request afterwards completes normally.
